// File: rtl/if_fetch.sv
// Instruction fetch unit: one outstanding memory read, single-entry output slot, branch redirect.
// Optional macro IF_MISALIGN_FAULT_EN turns misaligned redirect targets into a sticky fault that halts fetching.
module if_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  use_branch,
  input  logic [ADDR_WIDTH-1:0] branch_out,
  input  logic                  stall,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_inst,
  output logic                  misalign_fault
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  slot_free;
  logic                  bad_target;
  logic                  halted;
  logic [ADDR_WIDTH-1:0] branch_pc;

  assign slot_free = ~if_valid | ~stall;

`ifdef IF_MISALIGN_FAULT_EN
  logic fault_q;

  assign bad_target     = use_branch & (branch_out[1:0] != 2'b00);
  assign branch_pc      = branch_out;
  assign halted         = fault_q;
  assign misalign_fault = fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fault_q <= 1'b0;
    else if (bad_target)
      fault_q <= 1'b1;
  end
`else
  assign bad_target     = 1'b0;
  assign branch_pc      = branch_out & ~ADDR_WIDTH'(3);
  assign halted         = 1'b0;
  assign misalign_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= PC_ADDR;
      mem_req  <= 1'b0;
      mem_addr <= PC_ADDR;
      if_valid <= 1'b0;
      if_pc    <= PC_ADDR;
      if_inst  <= '0;
    end else begin
      if (if_valid && !stall)
        if_valid <= 1'b0;

      if (use_branch) begin
        // A redirect never aborts a bus request; an in-flight one is drained through DROP.
        if_valid <= 1'b0;
        if (!bad_target)
          pc <= branch_pc;
        case (state)
          FETCH, DROP: begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end else begin
              state   <= DROP;
            end
          end
          default: state <= IDLE;
        endcase
      end else begin
        case (state)
          IDLE: begin
            if (slot_free && !halted) begin
              state    <= FETCH;
              mem_req  <= 1'b1;
              mem_addr <= pc;
            end
          end
          FETCH: begin
            if (mem_ack) begin
              if_inst  <= mem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
              pc       <= pc + ADDR_WIDTH'(4);
              mem_req  <= 1'b0;
              state    <= IDLE;
            end
          end
          DROP: begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL provide parameter PC_ADDR, default 32'h8000_0000, the reset fetch address.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 32, the PC and memory address width.
REQ-003 SHALL provide parameter DATA_WIDTH, default 32, the instruction word width.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 use_branch  in  1  redirect request from the branch stage, sampled each cycle.
REQ-007 branch_out  in  ADDR_WIDTH  redirect target; valid only when use_branch=1.
REQ-008 stall  in  1  downstream not accepting; the held instruction is consumed in any cycle with if_valid=1 and stall=0.
REQ-009 mem_req  out  1  instruction memory read request, registered.
REQ-010 mem_addr  out  ADDR_WIDTH  read address, registered.
REQ-011 mem_ack  in  1  memory completion strobe, one cycle per request.
REQ-012 mem_rdata  in  DATA_WIDTH  read data, valid when mem_ack=1.
REQ-013 if_valid  out  1  if_inst/if_pc hold a live instruction.
REQ-014 if_pc  out  ADDR_WIDTH  address of if_inst.
REQ-015 if_inst  out  DATA_WIDTH  fetched instruction.
REQ-016 misalign_fault  out  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-017 SHALL implement states IDLE, FETCH and DROP, plus an internal pc register.
REQ-018 In IDLE, if use_branch=0 and the output slot is free or being consumed (if_valid=0 or stall=0), the block SHALL move to FETCH with mem_req<=1 and mem_addr<=pc.
REQ-019 In FETCH, mem_req and mem_addr SHALL stay constant until the cycle mem_ack=1.
REQ-020 On mem_ack in FETCH with use_branch=0: if_inst<=mem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, mem_req<=0, next state IDLE.
REQ-021 Latency: mem_ack in cycle N -> if_valid=1 in N+1 -> next mem_req=1 in N+2 (no stall, no redirect).
REQ-022 pc+4 SHALL wrap modulo 2^ADDR_WIDTH.
REQ-023 if_valid SHALL clear on consumption unless a new instruction is captured in the same edge.
REQ-024 use_branch=1 in any state SHALL set pc<=branch_out and if_valid<=0 on the same edge; no instruction from the old path is ever presented afterwards.
REQ-025 use_branch=1 in IDLE SHALL keep the state IDLE; the redirected request issues the following cycle.
REQ-026 use_branch=1 in FETCH with mem_ack=0 SHALL move to DROP; mem_req/mem_addr stay unchanged (requests are never aborted).
REQ-027 use_branch=1 in FETCH with mem_ack=1 SHALL discard mem_rdata, set mem_req<=0 and move to IDLE.
REQ-028 In DROP, mem_ack SHALL discard data, set mem_req<=0 and move to IDLE; a further use_branch in DROP SHALL overwrite pc with the newer target.
REQ-029 mem_ack outside FETCH/DROP SHALL be ignored.

Reset
REQ-030 While reset=1: state=IDLE, pc=PC_ADDR, mem_req=0, mem_addr=PC_ADDR, if_valid=0, if_pc=PC_ADDR, if_inst=0, misalign_fault=0.
REQ-031 Reset mid-fetch SHALL abandon the outstanding request; a mem_ack arriving after reset release while in IDLE SHALL be ignored per REQ-029.
REQ-032 The first mem_req after reset release SHALL assert in the second cycle after release, with mem_addr=PC_ADDR.

Configuration
REQ-033 With macro IF_MISALIGN_FAULT_EN defined, use_branch=1 with branch_out[1:0]!=0 SHALL set misalign_fault=1 (sticky until reset), clear if_valid, leave pc unchanged and inhibit all further requests (an in-flight request completes via DROP).
REQ-034 Without IF_MISALIGN_FAULT_EN, pc SHALL load {branch_out[ADDR_WIDTH-1:2],2'b00} and misalign_fault SHALL be tied to 0.

Verification
REQ-035 Reset release, mem_ack one cycle after each request, rdata=0x00000013 -> mem_addr sequence 0x80000000, 0x80000004, 0x80000008; if_pc matches each; if_valid one cycle after each ack.
REQ-036 stall=1 for 5 cycles with if_valid=1 -> if_inst/if_pc stable, no new mem_req until stall=0.
REQ-037 use_branch=1, branch_out=0x80000100 while FETCH is waiting (ack 3 cycles later) -> DROP; old data discarded; next mem_addr=0x80000100; if_valid never shows the old word.
REQ-038 pc=0xFFFFFFFC, ack -> next mem_addr=0x00000000.
REQ-039 use_branch and mem_ack in the same cycle -> data dropped, next mem_addr=branch_out.
REQ-040 IF_MISALIGN_FAULT_EN defined, branch_out=0x80000102 -> misalign_fault=1, mem_req stays 0 thereafter; undefined -> next mem_addr=0x80000100.
